conv_layer_mem: RTL and testbench

- Result-memory responder on the far end of the conv controller's crd/cwr/csel interface.
- Holds five banks: L0 kernel0/kernel1, L1 kernel0/kernel1 and flattened L2.
- Services single-port-style reads and writes selected by csel, with one-cycle registered read data.
- Keeps per-bank write counts and a sticky protocol-error flag for bench checking and downstream sequencing.

---
 rtl/conv_layer_mem.sv | 113 +++++++++++
 tb/tb_conv_layer_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_mem.sv
// Result memory for the conv controller: five banks packed into one array, with per-bank
// saturating write counters and a sticky protocol-error flag.
module conv_layer_mem #(
    parameter int DW       = 20,
    parameter int AW       = 12,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024,
    parameter int L2_DEPTH = 2048
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          crd,
    input  logic          cwr,
    input  logic [2:0]    csel,
    input  logic [AW-1:0] caddr_rd,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    output logic [DW-1:0] cdata_rd,
    output logic          cdata_rd_valid,
    output logic [4:0]    bank_full,
    output logic [12:0]   wr_cnt_sel,
    output logic          err
);

    localparam int CW        = 13;
    localparam int MEM_WORDS = 2*L0_DEPTH + 2*L1_DEPTH + L2_DEPTH;
    localparam int MW        = $clog2(MEM_WORDS);

    logic [DW-1:0] r_mem [MEM_WORDS];
    logic [CW-1:0] r_wr_cnt [5];
    logic [DW-1:0] r_cdata_rd;
    logic          r_cdata_rd_valid;
    logic          r_err;

    logic          w_bank_ok;
    logic [2:0]    w_bank_idx;
    logic [CW-1:0] w_depth;
    logic [MW-1:0] w_base;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_err_now;
    logic [MW-1:0] w_rd_idx;
    logic [MW-1:0] w_wr_idx;

    // Banks are laid out back to back: L0K0, L0K1, L1K0, L1K1, L2.
    always_comb begin
        w_bank_ok  = 1'b1;
        w_bank_idx = 3'd0;
        w_depth    = '0;
        w_base     = '0;
        case (csel)
            3'b001: begin w_bank_idx = 3'd0; w_depth = CW'(L0_DEPTH); w_base = MW'(0); end
            3'b010: begin w_bank_idx = 3'd1; w_depth = CW'(L0_DEPTH); w_base = MW'(L0_DEPTH); end
            3'b011: begin w_bank_idx = 3'd2; w_depth = CW'(L1_DEPTH); w_base = MW'(2*L0_DEPTH); end
            3'b100: begin w_bank_idx = 3'd3; w_depth = CW'(L1_DEPTH); w_base = MW'(2*L0_DEPTH + L1_DEPTH); end
            3'b101: begin w_bank_idx = 3'd4; w_depth = CW'(L2_DEPTH); w_base = MW'(2*L0_DEPTH + 2*L1_DEPTH); end
            default: w_bank_ok = 1'b0;
        endcase
    end

    assign w_rd_ok   = crd && w_bank_ok && (CW'(caddr_rd) < w_depth);
    assign w_wr_ok   = cwr && w_bank_ok && (CW'(caddr_wr) < w_depth);
    assign w_err_now = (crd && !w_rd_ok) || (cwr && !w_wr_ok);
    assign w_rd_idx  = w_base + MW'(caddr_rd);
    assign w_wr_idx  = w_base + MW'(caddr_wr);

    // Storage is never cleared; reset only blocks a write sampled on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            r_mem[w_wr_idx] <= cdata_wr;
        end
    end

    // The nonblocking read sees the pre-write word, giving read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdata_rd       <= '0;
            r_cdata_rd_valid <= 1'b0;
        end else begin
            r_cdata_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_cdata_rd <= r_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_wr_cnt[i] <= '0;
            end
        end else begin
            if (w_err_now) begin
                r_err <= 1'b1;
            end
            if (w_wr_ok && (r_wr_cnt[w_bank_idx] != w_depth)) begin
                r_wr_cnt[w_bank_idx] <= r_wr_cnt[w_bank_idx] + CW'(1);
            end
        end
    end

    assign bank_full[0]   = (r_wr_cnt[0] == CW'(L0_DEPTH));
    assign bank_full[1]   = (r_wr_cnt[1] == CW'(L0_DEPTH));
    assign bank_full[2]   = (r_wr_cnt[2] == CW'(L1_DEPTH));
    assign bank_full[3]   = (r_wr_cnt[3] == CW'(L1_DEPTH));
    assign bank_full[4]   = (r_wr_cnt[4] == CW'(L2_DEPTH));
    assign wr_cnt_sel     = w_bank_ok ? r_wr_cnt[w_bank_idx] : '0;
    assign cdata_rd       = r_cdata_rd;
    assign cdata_rd_valid = r_cdata_rd_valid;
    assign err            = r_err;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed bench for conv_layer_mem: a reference model pushes expected read words to a
// scoreboard queue at drive time and each clock step pops and compares them.
module tb_conv_layer_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        crd;
    logic        cwr;
    logic [2:0]  csel;
    logic [11:0] caddr_rd;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [19:0] cdata_rd;
    logic        cdata_rd_valid;
    logic [4:0]  bank_full;
    logic [12:0] wr_cnt_sel;
    logic        err;

    always #5 clk = ~clk;

    conv_layer_mem dut (
        .clk            (clk),
        .reset          (reset),
        .crd            (crd),
        .cwr            (cwr),
        .csel           (csel),
        .caddr_rd       (caddr_rd),
        .caddr_wr       (caddr_wr),
        .cdata_wr       (cdata_wr),
        .cdata_rd       (cdata_rd),
        .cdata_rd_valid (cdata_rd_valid),
        .bank_full      (bank_full),
        .wr_cnt_sel     (wr_cnt_sel),
        .err            (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] sb_q [$];
    logic [19:0] mdl [int];
    int          cnt [5];
    bit          exp_v;
    bit          exp_err;
    logic [19:0] last_data;

    function automatic int depth_of(input logic [2:0] s);
        case (s)
            3'd1, 3'd2: return 4096;
            3'd3, 3'd4: return 1024;
            3'd5:       return 2048;
            default:    return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] s, input int a);
        return a < depth_of(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit rd, input bit wr, input logic [2:0] sel,
                         input int ard, input int awr, input logic [19:0] dwr);
        reset    = rst;
        crd      = rd;
        cwr      = wr;
        csel     = sel;
        caddr_rd = ard[11:0];
        caddr_wr = awr[11:0];
        cdata_wr = dwr;
        exp_v    = 1'b0;
        if (rst) begin
            for (int i = 0; i < 5; i++) cnt[i] = 0;
            exp_err   = 1'b0;
            last_data = '0;
        end else begin
            if (rd) begin
                if (legal(sel, ard)) begin
                    exp_v = 1'b1;
                    sb_q.push_back(mdl[int'(sel) * 4096 + ard]);
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (wr) begin
                if (legal(sel, awr)) begin
                    mdl[int'(sel) * 4096 + awr] = dwr;
                    if (cnt[int'(sel) - 1] < depth_of(sel)) cnt[int'(sel) - 1]++;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        logic [4:0] exp_full;
        int         exp_cnt;
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(cdata_rd_valid), 32'(exp_v));
        if (exp_v && sb_q.size() > 0) last_data = sb_q.pop_front();
        chk("rd_data", 32'(cdata_rd), 32'(last_data));
        chk("err", 32'(err), 32'(exp_err));
        exp_cnt = (csel >= 3'd1 && csel <= 3'd5) ? cnt[int'(csel) - 1] : 0;
        chk("wr_cnt_sel", 32'(wr_cnt_sel), 32'(exp_cnt));
        for (int i = 0; i < 5; i++) exp_full[i] = (cnt[i] == depth_of(3'(i + 1)));
        chk("bank_full", 32'(bank_full), 32'(exp_full));
    endtask

    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [2:0] sel,
                       input int ard, input int awr, input logic [19:0] dwr);
        drive(rst, rd, wr, sel, ard, awr, dwr);
        step();
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 20'h0);
    endtask

    task automatic idle(input logic [2:0] sel);
        cyc(1'b0, 1'b0, 1'b0, sel, 0, 0, 20'h0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'd0, 0, 0, 20'h0);
        step();
        chk("reset_rd", 32'(cdata_rd), 32'h0);
        chk("reset_full", 32'(bank_full), 32'h0);
        idle(3'd0);

        // first write then read back
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 0, 5, 20'h0ABCD);
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 5, 0, 20'h0);
        chk("t1_data", 32'(cdata_rd), 32'h0ABCD);
        chk("t1_cnt", 32'(wr_cnt_sel), 32'd1);
        idle(3'd1);
        chk("t1_valid_drop", 32'(cdata_rd_valid), 32'd0);

        // bank isolation, read back-to-back
        for (int s = 1; s <= 5; s++) cyc(1'b0, 1'b0, 1'b1, 3'(s), 0, 7, 20'(s * 'h11));
        for (int s = 1; s <= 5; s++) begin
            cyc(1'b0, 1'b1, 1'b0, 3'(s), 7, 0, 20'h0);
            chk("iso_data", 32'(cdata_rd), 32'(s * 'h11));
        end
        chk("iso_err", 32'(err), 32'd0);

        // same-address read+write collision
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 0, 3, 20'h00100);
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 3, 3, 20'h00200);
        chk("rbw_old", 32'(cdata_rd), 32'h00100);
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 3, 0, 20'h0);
        chk("rbw_new", 32'(cdata_rd), 32'h00200);

        // fill L1K1 to saturation
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) chk("fill_pre_full", 32'(bank_full), 32'h0);
            cyc(1'b0, 1'b0, 1'b1, 3'd4, 0, i, 20'(i));
        end
        chk("fill_full", 32'(bank_full), 32'b01000);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 0, 0, 20'h77777);
        chk("fill_sat", 32'(wr_cnt_sel), 32'd1024);
        cyc(1'b0, 1'b1, 1'b0, 3'd4, 1023, 0, 20'h0);
        chk("fill_last", 32'(cdata_rd), 32'd1023);

        // protocol errors
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 0, 9, 20'h12345);
        idle(3'd7);
        chk("nostrobe_err", 32'(err), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd6, 0, 9, 20'h54321);
        chk("badsel_err", 32'(err), 32'd1);
        idle(3'd1);
        chk("badsel_cnt", 32'(wr_cnt_sel), 32'd1);
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 1024, 0, 20'h0);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_valid", 32'(cdata_rd_valid), 32'd0);
        for (int i = 0; i < 10; i++) idle(3'd0);
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("err_clear", 32'(err), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 0, 0, 20'h0);
        chk("sel0_err", 32'(err), 32'd1);
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 3, 1025, 20'h0DEAD);
        chk("split_rd", 32'(cdata_rd), 32'h00200);
        chk("split_err", 32'(err), 32'd1);
        chk("split_cnt", 32'(wr_cnt_sel), 32'd0);

        // reset in the middle of a read stream
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 0, 11, 20'h0BEEF);
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 5, 0, 20'h0);
        cyc(1'b0, 1'b1, 1'b0, 3'd2, 11, 0, 20'h0);
        cyc(1'b1, 1'b1, 1'b1, 3'd1, 5, 6, 20'h0F0F0);
        chk("mid_valid", 32'(cdata_rd_valid), 32'd0);
        chk("mid_data", 32'(cdata_rd), 32'h0);
        idle(3'd2);
        chk("mid_cnt", 32'(wr_cnt_sel), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 5, 0, 20'h0);
        chk("mid_keep", 32'(cdata_rd), 32'h0ABCD);
        cyc(1'b0, 1'b1, 1'b0, 3'd2, 11, 0, 20'h0);
        chk("mid_keep2", 32'(cdata_rd), 32'h0BEEF);
        idle(3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
